ex_alu_stage: RTL and testbench

- Execute-stage datapath: consumes the ALU control code produced by the EX ALU-control decoder, computes the ALU result and resolves branches and jal.
- Registers the outcome into the EX/MEM pipeline register.
- Issues a registered one-cycle PC redirect to fetch and internally squashes the single wrong-path instruction that follows a redirect.
- Sits between the ID/EX register and the MEM stage.

---
 rtl/ex_alu_stage.sv | 126 ++++++++++++
 tb/tb_ex_alu_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU, branch/jal resolution, EX/MEM register,
// registered PC redirect and single-slot wrong-path squash.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_LT   4'd7
`define ALU_NULL 4'd8
`endif

module ex_alu_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTL_W  = `ALU_CONTROL_WIDTH,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [ALU_CTL_W-1:0]  ALU_ctl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [XLEN-1:0]       store_data_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  is_branch_in,
  input  logic                  is_jal_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  valid_out,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       store_data_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] target;
  logic            lt;
  logic            is_sub;
  logic            is_lt;
  logic            taken;
  logic            squash;
  logic            accept;

  assign lt     = $signed(op_a) < $signed(op_b);
  assign is_sub = ALU_ctl == `ALU_SUB;
  assign is_lt  = ALU_ctl == `ALU_LT;

  always_comb begin
    alu_out = '0;
    unique case (1'b1)
      (ALU_ctl == `ALU_ADD): alu_out = op_a + op_b;
      (ALU_ctl == `ALU_SUB): alu_out = op_a - op_b;
      (ALU_ctl == `ALU_XOR): alu_out = op_a ^ op_b;
      (ALU_ctl == `ALU_OR):  alu_out = op_a | op_b;
      (ALU_ctl == `ALU_AND): alu_out = op_a & op_b;
      (ALU_ctl == `ALU_SLL): alu_out = op_a << op_b[4:0];
      (ALU_ctl == `ALU_SRL): alu_out = op_a >> op_b[4:0];
      (ALU_ctl == `ALU_LT):  alu_out = {{(XLEN-1){1'b0}}, lt};
      default:               alu_out = '0;
    endcase
  end

  // beq uses the SUB difference, blt the signed LT bit
  assign taken = is_jal_in
               | (is_branch_in & is_sub & (alu_out == '0))
               | (is_branch_in & is_lt & lt);

  assign result = is_jal_in ? pc_in + XLEN'(4) : alu_out;
  assign target = pc_in + imm_in;
  assign accept = valid_in & ~flush & ~squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out      <= 1'b0;
      alu_result     <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      squash         <= 1'b0;
    end else if (stall) begin
      redirect_valid <= 1'b0;
    end else if (accept) begin
      valid_out      <= 1'b1;
      alu_result     <= result;
      store_data_out <= store_data_in;
      rd_out         <= rd_in;
      reg_write_out  <= reg_write_in & ~is_branch_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      redirect_valid <= taken;
      squash         <= taken;
      if (taken)
        redirect_pc  <= target;
    end else begin
      valid_out      <= 1'b0;
      alu_result     <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      redirect_valid <= 1'b0;
      squash         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, branches, jal,
// stall hold and squash behaviour.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_LT   4'd7
`define ALU_NULL 4'd8
`endif

module tb_ex_alu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [3:0]  ALU_ctl;
  logic [31:0] op_a, op_b, store_data_in, pc_in, imm_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic        is_branch_in, is_jal_in, stall, flush;
  logic        valid_out;
  logic [31:0] alu_result, store_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_alu_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_ctl(ALU_ctl),
    .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in),
    .pc_in(pc_in), .imm_in(imm_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .is_branch_in(is_branch_in),
    .is_jal_in(is_jal_in), .stall(stall), .flush(flush),
    .valid_out(valid_out), .alu_result(alu_result),
    .store_data_out(store_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b);
    valid_in = 1'b1; ALU_ctl = c; op_a = a; op_b = b;
    store_data_in = 32'h0; pc_in = 32'h0; imm_in = 32'h0;
    rd_in = 5'd3; reg_write_in = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    is_branch_in = 1'b0; is_jal_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    op(`ALU_ADD, 32'd1, 32'd2);
    tick(); tick();
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_res", alu_result, 32'd0);
    chk("rst_rw", {31'b0, reg_write_out}, 32'd0);
    chk("rst_redir", {31'b0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);

    rst = 1'b0;
    op(`ALU_ADD, 32'h8000_0000, 32'h1); tick();
    chk("add", alu_result, 32'h8000_0001);
    chk("add_v", {31'b0, valid_out}, 32'd1);
    chk("add_rw", {31'b0, reg_write_out}, 32'd1);
    op(`ALU_SUB, 32'h8000_0000, 32'h1); tick();
    chk("sub", alu_result, 32'h7FFF_FFFF);
    op(`ALU_LT, 32'h8000_0000, 32'h1); tick();
    chk("lt", alu_result, 32'h1);
    op(`ALU_SRL, 32'h8000_0000, 32'h1); tick();
    chk("srl", alu_result, 32'h4000_0000);
    op(`ALU_SLL, 32'h8000_0000, 32'd33); tick();
    chk("sll33", alu_result, 32'h0);
    op(`ALU_XOR, 32'hF0F0_FFFF, 32'h0FF0_00FF); tick();
    chk("xor", alu_result, 32'hFF00_FF00);
    op(`ALU_NULL, 32'h1234, 32'h5678); tick();
    chk("null", alu_result, 32'h0);

    op(`ALU_ADD, 32'h100, 32'h4);
    mem_write_in = 1'b1; reg_write_in = 1'b0;
    store_data_in = 32'hDEAD_BEEF; tick();
    chk("sw_addr", alu_result, 32'h104);
    chk("sw_data", store_data_out, 32'hDEAD_BEEF);
    chk("sw_mw", {31'b0, mem_write_out}, 32'd1);

    // beq taken
    op(`ALU_SUB, 32'd5, 32'd5);
    is_branch_in = 1'b1; pc_in = 32'h100; imm_in = 32'h20; tick();
    chk("beq_redir", {31'b0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h120);
    chk("beq_rw", {31'b0, reg_write_out}, 32'd0);
    chk("beq_v", {31'b0, valid_out}, 32'd1);
    op(`ALU_ADD, 32'd1, 32'd2); tick();
    chk("sq_v", {31'b0, valid_out}, 32'd0);
    chk("sq_rw", {31'b0, reg_write_out}, 32'd0);
    chk("sq_redir", {31'b0, redirect_valid}, 32'd0);
    chk("sq_rpc_hold", redirect_pc, 32'h120);
    op(`ALU_SUB, 32'd5, 32'd6);
    is_branch_in = 1'b1; pc_in = 32'h300; imm_in = 32'h40; tick();
    chk("beq_nt_v", {31'b0, valid_out}, 32'd1);
    chk("beq_nt_redir", {31'b0, redirect_valid}, 32'd0);
    chk("beq_nt_rpc", redirect_pc, 32'h120);

    // jal with wrap
    op(`ALU_NULL, 32'd0, 32'd0);
    is_jal_in = 1'b1; pc_in = 32'hFFFF_FFFC; imm_in = 32'd8;
    rd_in = 5'd1; tick();
    chk("jal_res", alu_result, 32'h0);
    chk("jal_rpc", redirect_pc, 32'h4);
    chk("jal_rw", {31'b0, reg_write_out}, 32'd1);
    chk("jal_rd", {27'b0, rd_out}, 32'd1);
    chk("jal_redir", {31'b0, redirect_valid}, 32'd1);
    op(`ALU_ADD, 32'd3, 32'd4); tick();
    chk("jal_sq", {31'b0, valid_out}, 32'd0);

    // stall hold, flush ignored while stalled
    op(`ALU_ADD, 32'd3, 32'd4); tick();
    chk("add7", alu_result, 32'd7);
    stall = 1'b1; op(`ALU_ADD, 32'd10, 32'd20);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      chk("stl_res", alu_result, 32'd7);
      chk("stl_v", {31'b0, valid_out}, 32'd1);
      chk("stl_redir", {31'b0, redirect_valid}, 32'd0);
    end
    stall = 1'b0; flush = 1'b0; tick();
    chk("post_stl", alu_result, 32'd30);
    flush = 1'b1; tick();
    chk("flush_v", {31'b0, valid_out}, 32'd0);
    flush = 1'b0;

    // blt taken then stall: squash persists
    op(`ALU_LT, 32'hFFFF_FFFF, 32'd1);
    is_branch_in = 1'b1; pc_in = 32'h200; imm_in = 32'h40; tick();
    chk("blt_redir", {31'b0, redirect_valid}, 32'd1);
    chk("blt_rpc", redirect_pc, 32'h240);
    stall = 1'b1; op(`ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("blt_stl_redir", {31'b0, redirect_valid}, 32'd0);
      chk("blt_stl_res", alu_result, 32'd1);
    end
    stall = 1'b0; tick();
    chk("blt_sq_v", {31'b0, valid_out}, 32'd0);
    tick();
    chk("blt_next_v", {31'b0, valid_out}, 32'd1);
    chk("blt_next_res", alu_result, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
